// File: rtl/rob_commit_unit.sv
`default_nettype none
// ============================================================================
// rob_commit_unit
//   In-order reorder buffer: program-order allocation, out-of-order writeback,
//   in-order retirement with a full flush on an excepting head entry.
//   Optional feature macro: ROB_FULL_BYPASS_EN (allocate into the slot freed
//   by a commit in the same cycle when the buffer is full).
//   Revision: 1.0
// ============================================================================
module rob_commit_unit #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_valid,
  input  logic [4:0]        alloc_arch,
  output logic              alloc_ready,
  output logic [ADDR_W-1:0] alloc_tag,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_tag,
  input  logic              wb_exception,
  output logic              rob_commit_valid,
  output logic [4:0]        rob_commit_arch,
  output logic              exception_detected,
  output logic [ADDR_W:0]   rob_count
);

  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  done_q;
  logic [DEPTH-1:0]  exc_q;
  logic [4:0]        arch_q [DEPTH];
  logic [ADDR_W:0]   head_q;
  logic [ADDR_W:0]   tail_q;

  logic [ADDR_W-1:0] head_idx;
  logic [ADDR_W-1:0] tail_idx;
  logic              full;
  logic              head_valid;
  logic              head_done;
  logic              head_exc;
  logic              commit_fire;
  logic              exc_fire;
  logic              alloc_fire;
  logic              wb_fire;

  assign head_idx = head_q[ADDR_W-1:0];
  assign tail_idx = tail_q[ADDR_W-1:0];

  // Wrap bits distinguish full from empty when the indices coincide.
  assign full = (head_idx == tail_idx) && (head_q[ADDR_W] != tail_q[ADDR_W]);

  assign head_valid  = valid_q[head_idx];
  assign head_done   = done_q[head_idx];
  assign head_exc    = exc_q[head_idx];
  assign commit_fire = head_valid && head_done && !head_exc;
  assign exc_fire    = head_valid && head_done && head_exc;

`ifdef ROB_FULL_BYPASS_EN
  assign alloc_ready = (!full || commit_fire) && !exc_fire;
`else
  assign alloc_ready = !full && !exc_fire;
`endif

  assign alloc_fire = alloc_valid && alloc_ready;
  assign wb_fire    = wb_valid && valid_q[wb_tag];

  assign alloc_tag          = tail_idx;
  assign rob_commit_valid   = commit_fire;
  assign exception_detected = exc_fire;
  assign rob_commit_arch    = head_valid ? arch_q[head_idx] : 5'd0;
  assign rob_count          = tail_q - head_q;

  // Statement order matters: a freed head slot reused by a same-cycle
  // allocation must end up valid and not-done, so allocation is applied last.
  always_ff @(posedge clk) begin
    if (reset || exc_fire) begin
      valid_q <= '0;
      done_q  <= '0;
      exc_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      if (wb_fire) begin
        done_q[wb_tag] <= 1'b1;
        exc_q[wb_tag]  <= wb_exception;
      end
      if (commit_fire) begin
        valid_q[head_idx] <= 1'b0;
        head_q            <= head_q + PTR_ONE;
      end
      if (alloc_fire) begin
        valid_q[tail_idx] <= 1'b1;
        done_q[tail_idx]  <= 1'b0;
        exc_q[tail_idx]   <= 1'b0;
        tail_q            <= tail_q + PTR_ONE;
      end
    end
  end

  // Payload needs no reset: it is only observed through a valid entry.
  always_ff @(posedge clk) begin
    if (!reset && alloc_fire) begin
      arch_q[tail_idx] <= alloc_arch;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rob_commit_unit.sv
`default_nettype none
// ============================================================================
// tb_rob_commit_unit
//   Scoreboard bench: a queue-based program-order model predicts outputs and
//   retirement events; a separate monitor checks events as the DUT shows them.
//   Revision: 1.0
// ============================================================================
module tb_rob_commit_unit;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
`ifdef ROB_FULL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          alloc_valid;
  logic [4:0]    alloc_arch;
  logic          alloc_ready;
  logic [AW-1:0] alloc_tag;
  logic          wb_valid;
  logic [AW-1:0] wb_tag;
  logic          wb_exception;
  logic          rob_commit_valid;
  logic [4:0]    rob_commit_arch;
  logic          exception_detected;
  logic [AW:0]   rob_count;

  rob_commit_unit #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk                (clk),
    .reset              (reset),
    .alloc_valid        (alloc_valid),
    .alloc_arch         (alloc_arch),
    .alloc_ready        (alloc_ready),
    .alloc_tag          (alloc_tag),
    .wb_valid           (wb_valid),
    .wb_tag             (wb_tag),
    .wb_exception       (wb_exception),
    .rob_commit_valid   (rob_commit_valid),
    .rob_commit_arch    (rob_commit_arch),
    .exception_detected (exception_detected),
    .rob_count          (rob_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tag;
    logic [4:0] arch;
    bit         done;
    bit         exc;
  } ent_t;

  typedef struct {
    int         cyc;
    bit         exc;
    logic [4:0] arch;
  } ev_t;

  ent_t mq[$];
  ev_t  sb[$];
  int   tail_ptr = 0;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: check visible state, predict events, drive, advance model.
  task automatic step(input logic r, input logic av, input logic [4:0] a,
                      input logic wv, input logic [AW-1:0] t, input logic we);
    int         sz;
    bit         cmt, exc, rdy;
    logic [4:0] harch;
    sz    = mq.size();
    harch = (sz > 0) ? mq[0].arch : 5'd0;
    cmt   = (sz > 0) && mq[0].done && !mq[0].exc;
    exc   = (sz > 0) && mq[0].done && mq[0].exc;
    rdy   = ((sz != DEPTH) || (BYP && cmt)) && !exc;
    check("rob_count",   32'(rob_count),       32'(sz));
    check("alloc_ready", 32'(alloc_ready),     32'(rdy));
    check("alloc_tag",   32'(alloc_tag),       32'(tail_ptr % DEPTH));
    check("commit_arch", 32'(rob_commit_arch), 32'(harch));
    if (cmt || exc) sb.push_back('{cyc: cyc, exc: exc, arch: harch});
    reset        = r;
    alloc_valid  = av;
    alloc_arch   = a;
    wb_valid     = wv;
    wb_tag       = t;
    wb_exception = we;
    @(posedge clk);
    if (r || exc) begin
      mq.delete();
      tail_ptr = 0;
    end else begin
      if (wv) begin
        foreach (mq[i]) if (mq[i].tag == int'(t)) begin
          mq[i].done = 1'b1;
          mq[i].exc  = we;
        end
      end
      if (cmt) void'(mq.pop_front());
      if (av && rdy) begin
        mq.push_back('{tag: tail_ptr % DEPTH, arch: a, done: 1'b0, exc: 1'b0});
        tail_ptr = (tail_ptr + 1) % (2 * DEPTH);
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 5'd0, 0, '0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 5'd0, 0, '0, 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a retirement event.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        if (rob_commit_valid || exception_detected) begin
          n_checks++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL event: unexpected commit=%0b exc=%0b arch=%0d, none required (cycle %0d)",
                     rob_commit_valid, exception_detected, rob_commit_arch, cyc);
          end else begin
            e = sb.pop_front();
            if (e.cyc != cyc || exception_detected !== e.exc || rob_commit_valid !== !e.exc
                || rob_commit_arch !== e.arch) begin
              n_fail++;
              $display("FAIL event: got commit=%0b exc=%0b arch=%0d cycle %0d, required exc=%0b arch=%0d cycle %0d",
                       rob_commit_valid, exception_detected, rob_commit_arch, cyc, e.exc, e.arch, e.cyc);
            end
          end
        end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
          n_checks++;
          n_fail++;
          e = sb.pop_front();
          $display("FAIL event: got none, required exc=%0b arch=%0d at cycle %0d", e.exc, e.arch, e.cyc);
        end
      end
    end
  end

  initial begin
    logic [AW-1:0] t;
    reset = 1'b1; alloc_valid = 1'b0; alloc_arch = '0;
    wb_valid = 1'b0; wb_tag = '0; wb_exception = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;

    // In-order completion
    step(0, 1, 5'd1, 0, 0, 0);
    step(0, 1, 5'd2, 0, 0, 0);
    step(0, 1, 5'd3, 0, 0, 0);
    step(0, 0, 5'd0, 1, 0, 0);
    step(0, 0, 5'd0, 1, 1, 0);
    step(0, 0, 5'd0, 1, 2, 0);
    idle(3);

    // Out-of-order completion
    do_reset();
    step(0, 1, 5'd5, 0, 0, 0);
    step(0, 1, 5'd6, 0, 0, 0);
    step(0, 1, 5'd7, 0, 0, 0);
    step(0, 0, 5'd0, 1, 2, 0);
    step(0, 0, 5'd0, 1, 1, 0);
    step(0, 0, 5'd0, 1, 0, 0);
    idle(4);

    // Exception flush
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 1, 5'(10 + i), 0, 0, 0);
    step(0, 0, 5'd0, 1, 1, 1);
    step(0, 0, 5'd0, 1, 0, 0);
    step(0, 0, 5'd0, 1, 2, 0);
    step(0, 0, 5'd0, 1, 3, 0);
    idle(3);

    // Full, then stream through a wrap with dispatch held high
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(0, 1, 5'(16 + i), 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 5'(i), 1, 3'(i % DEPTH), 0);
    for (int i = 0; i < 12; i++) begin
      t = (mq.size() > 0) ? 3'(mq[0].tag) : 3'd0;
      step(0, 0, 5'd0, 1, t, 0);
    end

    // Reset mid-operation, then a late writeback to stale tags
    do_reset();
    step(0, 1, 5'd20, 0, 0, 0);
    step(0, 1, 5'd21, 0, 0, 0);
    step(0, 1, 5'd22, 0, 0, 0);
    step(0, 0, 5'd0, 1, 1, 0);
    step(0, 0, 5'd0, 1, 2, 0);
    do_reset();
    step(0, 0, 5'd0, 1, 1, 0);
    step(0, 0, 5'd0, 1, 0, 0);
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if (mq.size() > 0 && ($urandom % 4) != 0)
        t = 3'(mq[$urandom_range(0, mq.size() - 1)].tag);
      else
        t = 3'($urandom % DEPTH);
      step(($urandom % 200) == 0, ($urandom % 4) != 0, 5'($urandom),
           ($urandom % 4) != 0, t, ($urandom % 16) == 0);
    end
    idle(3);

    #3;
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rob_commit_unit.md
# rob_commit_unit

In-order reorder buffer that allocates entries in program order, accepts out-of-order completion writebacks, and presents the oldest completed instruction for retirement. It feeds the precise retirement stage directly through `rob_commit_valid`, `rob_commit_arch` and `exception_detected`. When the oldest entry carries an exception, the block flushes every younger entry so that architectural state stays precise.

## Interface

Parameters:
- `DEPTH`, default 8: number of entries; must be a power of two, ≥2.
- `ADDR_W`, default 3: log2(`DEPTH`); width of the tag/index.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state on a rising edge where it is high.
- `alloc_valid`  in  1  dispatch requests an entry this cycle.
- `alloc_arch`  in  5  architectural destination register of the dispatched instruction.
- `alloc_ready`  out  1  an entry can be accepted this cycle.
- `alloc_tag`  out  ADDR_W  index the next allocation receives (the tail index).
- `wb_valid`  in  1  a functional unit completes an instruction.
- `wb_tag`  in  ADDR_W  entry being completed.
- `wb_exception`  in  1  the completing instruction raised an exception.
- `rob_commit_valid`  out  1  head entry is retiring this cycle.
- `rob_commit_arch`  out  5  architectural destination of the head entry.
- `exception_detected`  out  1  head entry is an excepting instruction; a flush happens this cycle.
- `rob_count`  out  ADDR_W+1  number of occupied entries, 0..`DEPTH`.

## Operation

- Storage: per entry, `valid`, `done`, `exc` and `arch[4:0]`.
- Pointers: `head` and `tail`, each ADDR_W+1 bits including a wrap bit.
  - Empty: `head == tail`.
  - Full: index bits equal and wrap bits differ.
- Allocate fires when `alloc_valid && alloc_ready`:
  - The entry at `tail` is written with valid=1, done=0, exc=0, arch=`alloc_arch`.
  - `tail` increments and wraps modulo 2·`DEPTH`.
- Writeback occurs when `wb_valid` is high and the entry at `wb_tag` is valid:
  - That entry gets done=1 and exc=`wb_exception`.
  - A writeback to an invalid entry is ignored.
  - A repeated writeback overwrites `exc`.
- Commit occurs when the head entry has valid=1, done=1, exc=0:
  - `rob_commit_valid`=1 and `rob_commit_arch` = head arch.
  - On the edge, the entry is invalidated and `head` increments.
- Exception occurs when the head entry has valid=1, done=1, exc=1:
  - `exception_detected`=1, `rob_commit_valid`=0, and `rob_commit_arch` = head arch.
  - On the edge, all entries are invalidated, `head` and `tail` are set to 0, and `rob_count` is set to 0.
  - Any allocation or writeback in that same cycle is discarded.
- `alloc_ready` = !full && !`exception_detected`.
- `rob_count` changes by +1 on allocate, −1 on commit, and 0 when both happen in the same cycle.
- Priority within a cycle: `reset` > exception flush > {allocate, writeback, commit}. Allocate, writeback and commit update independently.

## Timing

- Outputs are decoded from registered state only; there is no combinational path from any input to any output.
- Reset values: `rob_commit_valid`=0, `exception_detected`=0, `rob_commit_arch`=0, `alloc_ready`=1, `alloc_tag`=0, `rob_count`=0.
- `rob_commit_arch` reads 0 whenever the head entry is invalid.
- Allocation at edge N makes the entry valid from cycle N+1.
  - A writeback in the same cycle as allocation, targeting the tail, is ignored.
  - The earliest accepted writeback is at edge N+1; commit is then visible in cycle N+2 and retires at edge N+2.
- Throughput: at most one commit per cycle.
  - Back-to-back completed entries retire on consecutive cycles.
  - `exception_detected` is a single-cycle pulse.
- Wrap-around: the index wraps from `DEPTH`−1 to 0 and the wrap bit toggles.
- Reset asserted mid-operation discards every entry on that edge.

## Configuration

- `ROB_FULL_BYPASS_EN` defined:
  - `alloc_ready` = (!full || commit firing this cycle) && !`exception_detected`.
  - When full, an allocation and a commit may both happen in one cycle; the freed slot is reused.
- `ROB_FULL_BYPASS_EN` undefined: `alloc_ready` = !full && !`exception_detected`; a full ROB stalls dispatch for at least one cycle after a commit.

## Test plan

- In-order completion: after reset, allocate arch 1, 2, 3 (tags 0, 1, 2), then write back tags 0, 1, 2 on consecutive cycles → `rob_commit_arch` shows 1, 2, 3 on consecutive cycles and `rob_count` returns to 0.
- Out-of-order completion: allocate arch 5, 6, 7, then write back tag 2, then 1, then 0 → no commit until tag 0 completes, then 5, 6, 7 retire on three consecutive cycles.
- Exception flush: allocate 4 entries, write back tag 1 with `wb_exception`=1, then tags 0, 2, 3 → tag 0 commits, then one `exception_detected` pulse with arch of tag 1, then `rob_count`=0 and `alloc_tag`=0; tags 2 and 3 never commit.
- Full and wrap:
  - Fill 8 entries → `alloc_ready`=0 and `rob_count`=8.
  - Complete head while holding `alloc_valid`: with the macro, allocation is accepted in the commit cycle; without it, allocation is accepted one cycle later.
  - Keep streaming → `alloc_tag` wraps 7→0.
- Reset mid-operation: with 3 entries valid and 2 done, assert `reset` for one cycle → all outputs at reset values, and a late writeback to the old tags produces no commit.
